iq_block_averager: RTL and testbench
====================================

Name: iq_block_averager

Overview:
- Multi-channel successor to the single-stream boxcar averager in the IQ receive path.
- Sums a runtime-programmable number of valid samples per channel (I and Q by default), scales the sums by a runtime shift, saturates, and presents one result word per block.
- Output uses a valid/ready handshake into the demodulator FIFO.
- Also produces the divided block-rate bit clock for the bit slicer.

Parameters:
- NBITS, 16, width of each input sample and each output average (signed).
- NCH, 2, number of channels packed in the data buses (channel 0 in the LSBs).
- ABITS, 10, accumulator growth bits; accumulator width is NBITS+ABITS.
- LEN_W, 10, width of block_len.
- BCW, 4, width of the completed-block counter; bit_clock is its MSB.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable  in  1  run control; low idles the block and discards any partial sum
- in_valid  in  1  sample strobe (equivalent of load_val)
- in_data  in  NCH*NBITS  packed signed samples
- block_len  in  LEN_W  samples per block; sampled at block start
- shift  in  5  right-shift applied to sums; values above ABITS are clamped to ABITS
- out_data  out  NCH*NBITS  packed signed averages, registered
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts when out_valid and out_ready are both high
- bit_clock  out  1  MSB of the completed-block counter
- overrun  out  1  sticky; a result was overwritten before being accepted
- sat  out  1  sticky; any channel saturated
- clr_flags  in  1  clears overrun and sat

Behaviour:
- Reset: state IDLE. Accumulators, sample counter, block counter, out_data, out_valid, overrun and sat are all 0. bit_clock is therefore 0.
- FSM state IDLE:
  - Counter and accumulators are held at 0.
  - When enable=1: latch len_q = (block_len==0 ? 1 : block_len), then go to ACCUM.
- FSM state ACCUM, on each in_valid=1:
  - If cnt < len_q-1: acc[c] += sext(in_data[c]) for every channel c, and cnt += 1.
  - If cnt == len_q-1 (last sample):
    - Compute sum[c] = acc[c] + sample[c].
    - Clear acc and cnt to 0 and re-latch len_q from block_len.
    - Increment the block counter, wrapping mod 2^BCW.
    - Load the output register (see Output) on the next clock edge.
  - No sample is dropped at the block boundary. The sample arriving on the cycle after the last sample starts the new block.
- ACCUM with in_valid=0: state holds.
- enable=0 in any state: go to IDLE next cycle and discard the partial sum.
  - A pending output and the block counter are retained.
  - If enable falls on the same cycle as the last sample, that completed block is still output.
- Arithmetic:
  - avg = sum >>> s with s = min(shift, ABITS); arithmetic shift, truncation toward negative infinity.
  - Saturate avg to [-2^(NBITS-1), 2^(NBITS-1)-1]; any clamp sets sat.
  - The accumulator cannot overflow while len_q <= 2^ABITS. Lengths above that wrap in two's complement (documented and unchecked).
- Output:
  - Result latency is 1 clock: out_data and out_valid are updated on the edge after the last sample.
  - out_valid stays high until a handshake. On a handshake with no new result, out_valid goes to 0 next cycle.
  - A new result arriving while out_valid=1 and out_ready=0 overwrites out_data, keeps out_valid=1, and sets overrun.
  - A new result coinciding with a handshake is not an overrun: out_valid stays 1 with the new data.
- Flags: clr_flags clears overrun and sat. If a set event and clr_flags occur in the same cycle, set wins.
- Reset mid-block: everything returns to reset values on the next edge, and any pending output is lost.

Optional Feature:
- Macro: IQ_AVG_ROUND_EN.
- Defined: before shifting, add 2^(s-1) to each sum when s>0 (round half up), then saturate.
- Undefined: pure truncation as above; no rounding adder is synthesised.

Test Plan:
- block_len=4, shift=2, enable=1, I=+100 and Q=-100 on 4 consecutive valids -> one cycle later out_valid=1, out_data I=100, Q=-100; block counter=1.
- block_len=0 treated as 1, shift=0, samples 5, 6, 7 -> three results 5, 6, 7 on consecutive cycles with out_ready=1; no overrun.
- block_len=2, shift=0, I=32767 on both samples -> I saturates to 32767, sat=1; clr_flags -> sat=0.
- Hold out_ready=0 across two completed blocks -> second block's data is presented, overrun=1, out_valid stays 1.
- block_len=3, enable dropped after 2 samples, then re-enabled, then 3 samples of 9 with shift=0 -> result 27 (partial sum discarded); with IQ_AVG_ROUND_EN, shift=1 and sum 27 -> 14 (13 when the macro is undefined).
- 16 completed blocks with BCW=4 -> bit_clock is low for blocks 0-7, high for 8-15, low again after wrap; assert rst mid-block -> all outputs 0 next cycle.

Source files
------------

// File: rtl/iq_block_averager_if.sv
// Sample-in / result-out bus of the IQ block averager.
//   in_valid  : sample strobe
//   in_data   : NCH packed signed samples, channel 0 in the LSBs
//   out_data  : NCH packed signed averages
//   out_valid : result available
//   out_ready : downstream accepts when out_valid and out_ready are both high
// modport slave  : averager side
// modport master : sample source / result sink side
interface iq_block_averager_if #(
  parameter int unsigned NBITS = 16,
  parameter int unsigned NCH   = 2
);
  logic                  in_valid;
  logic [NCH*NBITS-1:0]  in_data;
  logic [NCH*NBITS-1:0]  out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_data,
    output out_valid
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_data,
    input  out_valid
  );
endinterface

// File: rtl/iq_block_averager.sv
// Multi-channel block averager for the IQ receive path.
// Sums block_len valid samples per channel, scales each sum by an arithmetic right shift
// (clamped to ABITS), saturates to NBITS and presents one result word per block through a
// valid/ready handshake. The MSB of a wrapping completed-block counter is the bit-slicer clock.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   enable     : run control; low returns to idle and discards any partial sum
//   bus        : sample input and result output (iq_block_averager_if.slave)
//   block_len  : samples per block (0 treated as 1), latched at block start
//   shift      : right shift applied to the sums, clamped to ABITS
//   bit_clock  : MSB of the completed-block counter
//   overrun    : sticky, a result was overwritten before being accepted
//   sat        : sticky, a channel saturated
//   clr_flags  : clears overrun and sat (a coincident set event wins)
// Optional build macro IQ_AVG_ROUND_EN: round half up before shifting.
module iq_block_averager #(
  parameter int unsigned NBITS = 16,
  parameter int unsigned NCH   = 2,
  parameter int unsigned ABITS = 10,
  parameter int unsigned LEN_W = 10,
  parameter int unsigned BCW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  iq_block_averager_if.slave bus,
  input  logic [LEN_W-1:0] block_len,
  input  logic [4:0]       shift,
  output logic             bit_clock,
  output logic             overrun,
  output logic             sat,
  input  logic             clr_flags
);
  localparam int unsigned AW = NBITS + ABITS;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StAccum = 1'b1;

  // Saturation bounds expressed at the widened (AW+1) shift width.
  localparam logic signed [AW:0] SatMax = {{(ABITS + 2){1'b0}}, {(NBITS - 1){1'b1}}};
  localparam logic signed [AW:0] SatMin = {{(ABITS + 2){1'b1}}, {(NBITS - 1){1'b0}}};

  logic [0:0]             state_q, state_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       cnt_q, cnt_d;
  logic signed [AW-1:0]   acc_q [NCH];
  logic signed [AW-1:0]   acc_d [NCH];
  logic signed [AW-1:0]   acc_sum [NCH];
  logic [BCW-1:0]         blk_cnt_q;
  logic [NCH*NBITS-1:0]   out_data_q, res_data;
  logic                   out_valid_q, out_valid_d;
  logic                   overrun_q, sat_q;

  logic [LEN_W-1:0]       len_eff;
  logic [4:0]             s;
  logic                   last_smp, result_ev;
  logic [NCH-1:0]         clamp;
  logic [NBITS-1:0]       smp;
  logic signed [AW:0]     ext, shifted;

  assign len_eff   = (block_len == '0) ? LEN_W'(1) : block_len;
  assign s         = (shift > 5'(ABITS)) ? 5'(ABITS) : shift;
  assign last_smp  = (cnt_q == len_q - LEN_W'(1));
  // Completion does not depend on enable: a block finishing as enable falls is still output.
  assign result_ev = (state_q == StAccum) && bus.in_valid && last_smp;

  // Per-channel sum, scale and saturate of the block that completes this cycle.
  always_comb begin
    res_data = '0;
    clamp    = '0;
    smp      = '0;
    ext      = '0;
    shifted  = '0;
    for (int c = 0; c < NCH; c++) begin
      smp        = bus.in_data[c*NBITS +: NBITS];
      acc_sum[c] = acc_q[c] + {{ABITS{smp[NBITS-1]}}, smp};
      ext        = {acc_sum[c][AW-1], acc_sum[c]};
`ifdef IQ_AVG_ROUND_EN
      if (s != 5'd0) begin
        ext = ext + ((AW + 1)'(1) << (s - 5'd1));
      end
`endif
      shifted = ext >>> s;
      if (shifted > SatMax) begin
        res_data[c*NBITS +: NBITS] = SatMax[NBITS-1:0];
        clamp[c]                   = 1'b1;
      end else if (shifted < SatMin) begin
        res_data[c*NBITS +: NBITS] = SatMin[NBITS-1:0];
        clamp[c]                   = 1'b1;
      end else begin
        res_data[c*NBITS +: NBITS] = shifted[NBITS-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    for (int c = 0; c < NCH; c++) begin
      acc_d[c] = acc_q[c];
    end
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        for (int c = 0; c < NCH; c++) begin
          acc_d[c] = '0;
        end
        if (enable) begin
          len_d   = len_eff;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (bus.in_valid) begin
          if (last_smp) begin
            cnt_d = '0;
            len_d = len_eff;
            for (int c = 0; c < NCH; c++) begin
              acc_d[c] = '0;
            end
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
            for (int c = 0; c < NCH; c++) begin
              acc_d[c] = acc_sum[c];
            end
          end
        end
        if (!enable) begin
          state_d = StIdle;
          cnt_d   = '0;
          for (int c = 0; c < NCH; c++) begin
            acc_d[c] = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (result_ev) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      len_q       <= LEN_W'(1);
      cnt_q       <= '0;
      blk_cnt_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      sat_q       <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      for (int c = 0; c < NCH; c++) begin
        acc_q[c] <= acc_d[c];
      end
      if (result_ev) begin
        out_data_q <= res_data;
        blk_cnt_q  <= blk_cnt_q + BCW'(1);
      end
      // Overwrite only counts when the old result is not being accepted this cycle.
      if (result_ev && out_valid_q && !bus.out_ready) begin
        overrun_q <= 1'b1;
      end else if (clr_flags) begin
        overrun_q <= 1'b0;
      end
      if (result_ev && (|clamp)) begin
        sat_q <= 1'b1;
      end else if (clr_flags) begin
        sat_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bit_clock     = blk_cnt_q[BCW-1];
  assign overrun       = overrun_q;
  assign sat           = sat_q;
endmodule

// File: tb/tb_iq_block_averager.sv
module tb_iq_block_averager;
  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [9:0] block_len;
  logic [4:0] shift;
  logic       bit_clock, overrun, sat, clr_flags;

  int checks   = 0;
  int failures = 0;
  int blocks   = 0;
  logic [31:0] exp_q [$];

  iq_block_averager_if #(.NBITS(16), .NCH(2)) bus ();

  iq_block_averager dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .bus       (bus),
    .block_len (block_len),
    .shift     (shift),
    .bit_clock (bit_clock),
    .overrun   (overrun),
    .sat       (sat),
    .clr_flags (clr_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [15:0] i, input logic signed [15:0] q);
    bus.in_valid = 1'b1;
    bus.in_data  = {q, i};
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_res(input logic signed [15:0] i, input logic signed [15:0] q);
    exp_q.push_back({q, i});
  endtask

  task automatic restart(input logic [9:0] len, input logic [4:0] sh);
    enable = 1'b0;
    tick();
    block_len = len;
    shift     = sh;
    enable    = 1'b1;
    tick();
  endtask

  // Monitor: a transfer occurs at the next rising edge when valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got 0x%08h expected no output", bus.out_data);
      end else begin
        check("sb_data", bus.out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst          = 1'b1;
    enable       = 1'b0;
    block_len    = '0;
    shift        = '0;
    clr_flags    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_bit_clock", 32'(bit_clock), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    rst = 1'b0;

    // Block of 4, shift 2: 400/4 and -400/4.
    block_len = 10'd4;
    shift     = 5'd2;
    enable    = 1'b1;
    tick();
    expect_res(16'sd100, -16'sd100);
    repeat (4) send(16'sd100, -16'sd100);
    blocks++;
    check("lat1_valid", 32'(bus.out_valid), 32'd1);
    tick();
    check("hs_valid_low", 32'(bus.out_valid), 32'd0);
    check("blk1_bit_clock", 32'(bit_clock), 32'd0);

    // block_len 0 acts as 1: one result per sample, back to back.
    restart(10'd0, 5'd0);
    expect_res(16'sd5, -16'sd5);
    expect_res(16'sd6, -16'sd6);
    expect_res(16'sd7, -16'sd7);
    send(16'sd5, -16'sd5);
    send(16'sd6, -16'sd6);
    send(16'sd7, -16'sd7);
    blocks += 3;
    tick();
    tick();
    check("b2b_overrun", 32'(overrun), 32'd0);
    check("b2b_drained", 32'(exp_q.size()), 32'd0);

    // Saturation both ways, then clear.
    restart(10'd2, 5'd0);
    expect_res(16'sd32767, -16'sd32768);
    repeat (2) send(16'sd32767, -16'sd32768);
    blocks++;
    check("sat_set", 32'(sat), 32'd1);
    tick();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("sat_clr", 32'(sat), 32'd0);

    // Two blocks with out_ready low: second overwrites first.
    bus.out_ready = 1'b0;
    expect_res(16'sd7, -16'sd7);
    send(16'sd10, -16'sd10);
    send(16'sd10, -16'sd10);
    send(16'sd3, -16'sd3);
    send(16'sd4, -16'sd4);
    blocks += 2;
    check("ovr_set", 32'(overrun), 32'd1);
    tick();
    tick();
    check("ovr_valid_held", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    check("ovr_valid_drop", 32'(bus.out_valid), 32'd0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("ovr_clr", 32'(overrun), 32'd0);

    // Partial block discarded by enable drop.
    restart(10'd3, 5'd0);
    send(16'sd9, -16'sd9);
    send(16'sd9, -16'sd9);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    expect_res(16'sd27, -16'sd27);
    repeat (3) send(16'sd9, -16'sd9);
    blocks++;
    check("blk8_bit_clock", 32'(bit_clock), 32'd1);

    // Shift 1 on sum 27 / -27.
    shift = 5'd1;
`ifdef IQ_AVG_ROUND_EN
    expect_res(16'sd14, -16'sd13);
`else
    expect_res(16'sd13, -16'sd14);
`endif
    repeat (3) send(16'sd9, -16'sd9);
    blocks++;
    tick();
    check("shift_drained", 32'(exp_q.size()), 32'd0);

    // Shift above ABITS clamps to 10: 2048 >>> 10 = 2.
    restart(10'd1, 5'd31);
    expect_res(16'sd2, -16'sd2);
    send(16'sd2048, -16'sd2048);
    blocks++;

    // Walk the block counter through a wrap.
    shift = 5'd0;
    for (int k = 0; k < 16; k++) begin
      expect_res(16'(k + 1), 16'(-(k + 1)));
      send(16'(k + 1), 16'(-(k + 1)));
      blocks++;
      check("bit_clock_walk", 32'(bit_clock), 32'((blocks >> 3) & 1));
    end
    tick();
    check("walk_drained", 32'(exp_q.size()), 32'd0);

    // Reset with a pending result, overrun set and a block in progress.
    bus.out_ready = 1'b0;
    send(16'sd50, -16'sd50);
    send(16'sd51, -16'sd51);
    restart(10'd3, 5'd0);
    send(16'sd1, 16'sd1);
    rst = 1'b1;
    tick();
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_data", bus.out_data, 32'd0);
    check("mid_rst_bit_clock", 32'(bit_clock), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    check("mid_rst_sat", 32'(sat), 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("end_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
